// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Shares one combinational WIDTHxWIDTH multiplier between NREQ
//            requesters. A winner is picked among pending requests. Its
//            operands are registered onto the multiplier inputs. The block
//            then waits MULT_LAT cycles for the array to settle, captures
//            the product and pulses a one-cycle acknowledge to the owner.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   MULT_ARB_FIXED_PRIO_EN - when defined, the lowest-index pending request
//                            always wins and the round-robin pointer is
//                            removed. When undefined (default), round-robin
//                            arbitration is used. Timing is identical in
//                            both modes.
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   1           rising-edge clock
//   rst      in   1           asynchronous active-low reset (0 = reset)
//   req      in   NREQ        per-requester request level, held until ack
//   a_bus    in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_bus    in   NREQ*WIDTH  operand B, same packing
//   grant    out  NREQ        one-hot current owner, 0 when idle
//   ack      out  NREQ        one-hot single-cycle pulse, result valid
//   result   out  2*WIDTH     captured product, held between acks
//   busy     out  1           high while an operation is in flight
//   mult_a   out  WIDTH       registered operand A to the shared multiplier
//   mult_b   out  WIDTH       registered operand B to the shared multiplier
//   mult_out in   2*WIDTH     product from the shared multiplier
// ============================================================================
module mult_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 2,
  parameter int CNT_SIZE = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_bus,
  input  logic [NREQ*WIDTH-1:0]   b_bus,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic [2*WIDTH-1:0]      result,
  output logic                    busy,
  output logic [WIDTH-1:0]        mult_a,
  output logic [WIDTH-1:0]        mult_b,
  input  logic [2*WIDTH-1:0]      mult_out
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter value on the final settle cycle of WAIT.
  localparam logic [CNT_SIZE-1:0] CNT_LAST = CNT_SIZE'(MULT_LAT - 1);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CNT_SIZE-1:0] cnt;

  logic                any_req;
  logic [IDX_W-1:0]    win_idx;
  logic [NREQ-1:0]     win_onehot;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;

  logic [WIDTH-1:0]    a_arr [NREQ];
  logic [WIDTH-1:0]    b_arr [NREQ];

  // --------------------------------------------------------------------------
  // Unpack the flat operand buses into per-requester arrays
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = a_bus[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = b_bus[gi*WIDTH +: WIDTH];
  end

  assign any_req = |req;

`ifdef MULT_ARB_FIXED_PRIO_EN
  // --------------------------------------------------------------------------
  // Fixed priority: the lowest pending index wins. The scan runs from the top
  // down so that the last assignment, the lowest index, takes effect.
  // --------------------------------------------------------------------------
  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_idx = IDX_W'(k);
      end
    end
  end
`else
  // --------------------------------------------------------------------------
  // Round-robin: the pointer names the requester with top priority. After
  // each completed operation it moves to the owner's successor.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;

  // Requester index at rotation offset offs from base, modulo NREQ.
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                               input int               offs);
    int j;
    j = int'(base) + offs;
    if (j >= NREQ) begin
      j = j - NREQ;
    end
    return IDX_W'(j);
  endfunction

  // The scan walks from the largest offset down, so the smallest offset from
  // the pointer that is pending ends up as the winner.
  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rot_idx(ptr, k)]) begin
        win_idx = rot_idx(ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      owner <= '0;
    end else begin
      if ((state == ST_IDLE) && any_req) begin
        owner <= win_idx;
      end
      if (state == ST_DONE) begin
        ptr <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Winner decode: one-hot grant and operand selection
  // --------------------------------------------------------------------------
  always_comb begin
    sel_a      = '0;
    sel_b      = '0;
    win_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        sel_a         = a_arr[k];
        sel_b         = b_arr[k];
        win_onehot[k] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req)         state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE:                      state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state == ST_WAIT) || (state == ST_DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath registers: grant/operand latch, settle counter, result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant  <= '0;
      ack    <= '0;
      result <= '0;
      mult_a <= '0;
      mult_b <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant  <= win_onehot;
            mult_a <= sel_a;
            mult_b <= sel_b;
            cnt    <= '0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_SIZE'(1);
          // The multiplier inputs have been stable for MULT_LAT cycles.
          if (cnt == CNT_LAST) begin
            result <= mult_out;
            ack    <= grant;
          end
        end
        ST_DONE: begin
          ack   <= '0;
          grant <= '0;
        end
        default: begin
          ack   <= '0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
